// File: rtl/rams32_arbiter_if.sv
// Bus bundle between rams32_arbiter, its two requesters and the 32x1 RAM cell.
//   req0/we0/adr0/din0   requester 0 access request, type, address, write data
//   gnt0/rvalid0/rdata0  requester 0 grant, read-data valid pulse, read data
//   req1..rdata1         the same set for requester 1
//   busy                 high while the post-reset clear sweep runs
//   ram_adr/ram_i/ram_we RAM address, data input and write enable
//   ram_o                RAM asynchronous data output
// Modport slave is the arbiter's view; modport master is the client/RAM side.
interface rams32_arbiter_if;
  logic       req0;
  logic       we0;
  logic [4:0] adr0;
  logic       din0;
  logic       gnt0;
  logic       rvalid0;
  logic       rdata0;

  logic       req1;
  logic       we1;
  logic [4:0] adr1;
  logic       din1;
  logic       gnt1;
  logic       rvalid1;
  logic       rdata1;

  logic       busy;
  logic [4:0] ram_adr;
  logic       ram_i;
  logic       ram_we;
  logic       ram_o;

  modport slave (
    input  req0, we0, adr0, din0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, adr1, din1,
    output gnt1, rvalid1, rdata1,
    output busy,
    output ram_adr, ram_i, ram_we,
    input  ram_o
  );

  modport master (
    output req0, we0, adr0, din0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, adr1, din1,
    input  gnt1, rvalid1, rdata1,
    input  busy,
    input  ram_adr, ram_i, ram_we,
    output ram_o
  );
endinterface

// File: rtl/rams32_arbiter.sv
// Sequencer and two-port round-robin arbiter for a single 32x1 distributed RAM
// cell (asynchronous read, synchronous write).  After reset it optionally
// writes CLR_VAL into all 32 locations, then shares the RAM between two
// requesters with a combinational same-cycle grant and registered read data.
//   CLK    clock, all state changes on the rising edge
//   RST_N  asynchronous active-low reset
//   bus    rams32_arbiter_if.slave: requester handshakes, busy, RAM pins
module rams32_arbiter #(
  parameter logic CLR_VAL      = 1'b0,
  parameter bit   CLEAR_ON_RST = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  rams32_arbiter_if.slave       bus
);

  // One-hot style encodings leave 2'b00 and 2'b11 unreachable; both fall
  // back to RUN through the default branch.
  localparam logic [1:0] ST_CLEAR = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_RESET = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [4:0] clr_cnt;
  logic       last_gnt;   // 1 = requester 1 won most recently

  logic       gnt0;
  logic       gnt1;
  logic       rd0;
  logic       rd1;
  logic [4:0] ram_adr;
  logic       ram_i;
  logic       ram_we;
  logic       busy;

  logic       rvalid0_p1;
  logic       rvalid1_p1;
  logic       rdata0_p1;
  logic       rdata1_p1;

  always_comb begin
    state_nxt = ST_RUN;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_adr   = 5'd0;
    ram_i     = 1'b0;
    ram_we    = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        // Requests are ignored here and simply remain pending.
        ram_adr   = clr_cnt;
        ram_i     = CLR_VAL;
        ram_we    = 1'b1;
        busy      = 1'b1;
        state_nxt = (clr_cnt == 5'd31) ? ST_RUN : ST_CLEAR;
      end
      ST_RUN: begin
        // On a tie the requester that did not win last time is granted.
        gnt0 = bus.req0 & (~bus.req1 | last_gnt);
        gnt1 = bus.req1 & (~bus.req0 | ~last_gnt);
        if (gnt0) begin
          ram_adr = bus.adr0;
          ram_i   = bus.din0;
          ram_we  = bus.we0;
        end else if (gnt1) begin
          ram_adr = bus.adr1;
          ram_i   = bus.din1;
          ram_we  = bus.we1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign rd0 = gnt0 & ~bus.we0;
  assign rd1 = gnt1 & ~bus.we1;

  // Stage p0 -> p1: grant cycle samples the asynchronous RAM output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_RESET;
      clr_cnt    <= 5'd0;
      last_gnt   <= 1'b1;
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
      rdata0_p1  <= 1'b0;
      rdata1_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 5'd1;   // wraps 31 -> 0 as the sweep ends
      end
      if (gnt0) begin
        last_gnt <= 1'b0;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
      end
      rvalid0_p1 <= rd0;
      rvalid1_p1 <= rd1;
      if (rd0) begin
        rdata0_p1 <= bus.ram_o;
      end
      if (rd1) begin
        rdata1_p1 <= bus.ram_o;
      end
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_p1;
  assign bus.rvalid1 = rvalid1_p1;
  assign bus.rdata0  = rdata0_p1;
  assign bus.rdata1  = rdata1_p1;
  assign bus.busy    = busy;
  assign bus.ram_adr = ram_adr;
  assign bus.ram_i   = ram_i;
  assign bus.ram_we  = ram_we;

endmodule

// File: tb/tb_rams32_arbiter.sv
module tb_rams32_arbiter;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  rams32_arbiter_if bus ();
  rams32_arbiter_if bus2 ();

  rams32_arbiter #(.CLR_VAL(1'b1), .CLEAR_ON_RST(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  rams32_arbiter #(.CLR_VAL(1'b0), .CLEAR_ON_RST(1'b0)) dut_nc (
    .CLK(CLK), .RST_N(RST_N), .bus(bus2)
  );

  // 32x1 RAM cell models: synchronous write, asynchronous read.
  logic [31:0] mem  = 32'h0000_0000;
  logic [31:0] mem2 = 32'hA5A5_0F0F;
  always @(posedge CLK) if (bus.ram_we) mem[bus.ram_adr] <= bus.ram_i;
  always @(posedge CLK) if (bus2.ram_we) mem2[bus2.ram_adr] <= bus2.ram_i;
  assign bus.ram_o  = mem[bus.ram_adr];
  assign bus2.ram_o = mem2[bus2.ram_adr];

  int checks = 0;
  int errors = 0;
  logic q0[$];
  logic q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read data whenever the DUT presents rvalid,
  // and checks per-cycle grant/valid relationships.
  logic prev_rst = 1'b0, prev_rd0 = 1'b0, prev_rd1 = 1'b0;
  always @(negedge CLK) begin
    if (RST_N) begin
      if (bus.rvalid0) begin
        if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
        else chk("rdata0", bus.rdata0, q0.pop_front());
      end
      if (bus.rvalid1) begin
        if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
        else chk("rdata1", bus.rdata1, q1.pop_front());
      end
      chk("gnt_exclusive", bus.gnt0 & bus.gnt1, 0);
      if (prev_rst) begin
        chk("rvalid0_timing", bus.rvalid0, prev_rd0);
        chk("rvalid1_timing", bus.rvalid1, prev_rd1);
      end
    end
    prev_rst = RST_N;
    prev_rd0 = bus.gnt0 & ~bus.we0;
    prev_rd1 = bus.gnt1 & ~bus.we1;
  end

  // Issue one access on requester 0; caller is at posedge+1.
  task automatic access0(input logic we, input logic [4:0] adr, input logic din,
                         input logic exp, input int max_wait);
    int waited;
    bit got;
    got = 0;
    waited = 0;
    bus.req0 = 1'b1; bus.we0 = we; bus.adr0 = adr; bus.din0 = din;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (bus.gnt0) begin got = 1; break; end
      waited++;
      @(posedge CLK); #1;
    end
    if (!got) begin
      chk("gnt0_timeout", 0, 1);
    end else begin
      if (!we) q0.push_back(exp);
      chk("gnt0_wait", (waited <= max_wait), 1);
      @(posedge CLK); #1;
    end
    bus.req0 = 1'b0;
  endtask

  task automatic access1(input logic we, input logic [4:0] adr, input logic din,
                         input logic exp, input int max_wait);
    int waited;
    bit got;
    got = 0;
    waited = 0;
    bus.req1 = 1'b1; bus.we1 = we; bus.adr1 = adr; bus.din1 = din;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (bus.gnt1) begin got = 1; break; end
      waited++;
      @(posedge CLK); #1;
    end
    if (!got) begin
      chk("gnt1_timeout", 0, 1);
    end else begin
      if (!we) q1.push_back(exp);
      chk("gnt1_wait", (waited <= max_wait), 1);
      @(posedge CLK); #1;
    end
    bus.req1 = 1'b0;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_ram_adr"}, bus.ram_adr, i);
      chk({tag, "_ram_we"}, bus.ram_we, 1);
      chk({tag, "_ram_i"}, bus.ram_i, 1);
      chk({tag, "_gnt0_blocked"}, bus.gnt0, 0);
      @(posedge CLK);
    end
    #1;
  endtask

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.adr0 = 0; bus.din0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.adr1 = 0; bus.din1 = 0;
    bus2.req0 = 0; bus2.we0 = 0; bus2.adr0 = 0; bus2.din0 = 0;
    bus2.req1 = 0; bus2.we1 = 0; bus2.adr1 = 0; bus2.din1 = 0;

    // Reset state; requester 0 already requesting a read of address 17.
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 5'd17;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", bus.busy, 1);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_nc_busy", bus2.busy, 0);
    @(posedge CLK); #1;
    RST_N = 1;
    bus2.req0 = 1; bus2.we0 = 0; bus2.adr0 = 5'd3;

    // No-clear instance is granted in the first cycle after release.
    @(negedge CLK);
    chk("nc_gnt0_first", bus2.gnt0, 1);
    chk("nc_busy", bus2.busy, 0);
    chk("sweep_start_adr", bus.ram_adr, 0);
    @(posedge CLK); #1;
    bus2.req0 = 0;
    @(negedge CLK);
    chk("nc_rvalid0", bus2.rvalid0, 1);
    chk("nc_rdata0", bus2.rdata0, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("nc_rvalid0_drop", bus2.rvalid0, 0);

    // Restart cleanly to observe the whole sweep from address 0.
    RST_N = 0;
    @(posedge CLK); #1;
    RST_N = 1;
    sweep_check("sweep1");
    @(negedge CLK);
    chk("busy_fall", bus.busy, 0);
    chk("gnt0_after_sweep", bus.gnt0, 1);
    q0.push_back(1'b1);                   // address 17 was cleared to 1
    @(posedge CLK); #1;
    bus.req0 = 0;

    // Write then read-after-write on requester 0.
    access0(1, 5'd5, 0, 0, 0);
    access0(0, 5'd5, 0, 0, 0);
    access0(1, 5'd5, 1, 0, 0);
    access0(0, 5'd5, 0, 1, 0);

    // One requester-1 access leaves last_gnt=1, so a tie goes to 0 first.
    access1(1, 5'd4, 0, 0, 0);
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 5'd3;
    bus.req1 = 1; bus.we1 = 0; bus.adr1 = 5'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("alt_gnt0", bus.gnt0, (k % 2 == 0));
      chk("alt_gnt1", bus.gnt1, (k % 2 == 1));
      if (bus.gnt0) q0.push_back(1'b1);
      if (bus.gnt1) q1.push_back(1'b0);
      @(posedge CLK); #1;
    end
    bus.req0 = 0;

    // Requester 1 alone for 3 cycles, then a tie that requester 0 wins.
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("solo_gnt1", bus.gnt1, 1);
      chk("solo_gnt0", bus.gnt0, 0);
      if (bus.gnt1) q1.push_back(1'b0);
      @(posedge CLK); #1;
    end
    bus.req0 = 1; bus.we0 = 0; bus.adr0 = 5'd17;
    @(negedge CLK);
    chk("tie_gnt0", bus.gnt0, 1);
    chk("tie_gnt1", bus.gnt1, 0);
    if (bus.gnt0) q0.push_back(1'b1);
    @(posedge CLK); #1;
    bus.req0 = 0;
    @(negedge CLK);
    chk("tie_next_gnt1", bus.gnt1, 1);
    if (bus.gnt1) q1.push_back(1'b0);
    @(posedge CLK); #1;
    bus.req1 = 0;

    // Leave a 0 at address 20 and rdata0=1, then reset mid-sweep.
    access0(1, 5'd20, 0, 0, 0);
    access0(0, 5'd20, 0, 0, 0);
    access0(0, 5'd17, 0, 1, 0);
    repeat (3) begin @(posedge CLK); #1; end
    chk("q_drained", q0.size() + q1.size(), 0);

    RST_N = 0;
    @(negedge CLK);
    chk("rst2_rdata0", bus.rdata0, 0);
    chk("rst2_rvalid0", bus.rvalid0, 0);
    @(posedge CLK); #1;
    RST_N = 1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge CLK);
      chk("pre_abort_adr", bus.ram_adr, i);
      if (i < 10) @(posedge CLK);
    end
    RST_N = 0;
    #1;
    chk("abort_busy", bus.busy, 1);
    chk("abort_adr", bus.ram_adr, 0);
    @(posedge CLK); #1;
    RST_N = 1;
    sweep_check("sweep2");
    @(negedge CLK);
    chk("busy_fall2", bus.busy, 0);
    @(posedge CLK); #1;
    access0(0, 5'd20, 0, 1, 0);           // sweep rewrote address 20
    access1(0, 5'd4, 0, 1, 0);
    repeat (3) begin @(posedge CLK); #1; end
    chk("q_empty_end", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", checks);
    $fatal(1, "timeout");
  end

endmodule
